vdp_layer_mixer: RTL and testbench
==================================

# vdp_layer_mixer

Per-pixel compositor directly downstream of the sprite core. Each cycle it takes the sprite line-buffer pixel (8-bit palette index plus 2-bit priority) and the four tilemap layer pixels, resolves transparency and layer priority, and emits one 8-bit palette index to the palette/video-output stage. It also latches the first sprite-versus-background collision of each frame for host readback.

## Interface
Parameters:
- COLLISION_ENABLE, default 1: when 0, collision logic is removed; collision outputs are tied to 0.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- pixel_valid  in  1  active-display strobe, aligned with all pixel inputs
- start_new_frame  in  1  one-cycle pulse before the first active line
- render_x  in  10  x of the current input pixel
- render_y  in  9  y of the current input pixel
- layer_enable  in  5  bit 4 = sprites; bits 3:0 = tilemap layers 3..0
- sprite_pixel  in  8  sprite palette index (pppp cccc)
- sprite_priority  in  2  sprite priority
- layer0_pixel .. layer3_pixel  in  8 each  tilemap palette indices; layer 0 is frontmost
- collision_clear  in  1  host write strobe that clears the collision latch
- output_pixel  out  8  resolved palette index
- output_valid  out  1  pixel_valid delayed to match output_pixel
- collision_flag  out  1  sticky sprite/background collision
- collision_x  out  10  x of the latched collision
- collision_y  out  9  y of the latched collision

## Operation
- Opacity: a source is opaque when its enable bit is 1 and pixel[3:0] != 0. Otherwise it is transparent.
- Layer order, front to back: L0, L1, L2, L3.
- Sprite placement by sprite_priority p:
  - p = 3: in front of all layers.
  - p = 2: behind L0 only.
  - p = 1: behind L0 and L1.
  - p = 0: behind L0, L1 and L2; still in front of L3.
- Resolution: output_pixel is the frontmost opaque source in this order. If every source is transparent, output_pixel = 8'h00 (backdrop).
- When pixel_valid was 0 for the emitted pixel, output_pixel = 8'h00 and output_valid = 0.
- Collision event: pixel_valid = 1, the sprite is opaque, and at least one tilemap layer is opaque. Depth order does not matter.
- Collision state machine:
  - ARMED: on a collision event, go to LATCHED and capture collision_x/collision_y from that pixel's render_x/render_y.
  - LATCHED: ignore further events. collision_clear or start_new_frame returns to ARMED and clears collision_flag. collision_x/y hold their values until the next capture.
  - collision_flag = 1 exactly in LATCHED.
- Simultaneous events:
  - A clear (collision_clear or start_new_frame) and a collision event in the same cycle: the new event is captured, the state stays/ends LATCHED, and the coordinates update.
  - collision_clear and start_new_frame together behave as a single clear.
- render_x/render_y travel down the pipeline with the pixel, unmodified. Nothing wraps; the values are captured as given.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the inputs and computes per-source opacity.
  - Stage 2 resolves priority and registers output_pixel/output_valid.
- Latency: an input at edge N appears on the outputs after edge N+2. Throughput is one pixel per cycle with no stalls.
- Collision detection uses stage-2 data, so collision_flag rises on the same edge that output_valid shows the colliding pixel.
- collision_clear and start_new_frame take effect at the next edge. collision_flag is 0 in the following cycle unless a new event coincides.
- Reset values: output_pixel = 0, output_valid = 0, collision_flag = 0, collision_x = 0, collision_y = 0, state ARMED, both pipeline valid bits = 0.
- Reset asserted mid-line flushes the pipeline. After release, output_valid stays 0 for 2 cycles even if pixel_valid is held high.
- layer_enable is sampled in stage 1, with the pixel it applies to.

## Test plan
- Sprite 8'h35, p = 1, L0 = 8'h00, L1 = 8'h12, L2 = 8'h47, all enabled -> output_pixel = 8'h12 two cycles later, output_valid = 1.
- Same inputs with L1 = 8'h10 (transparent) -> 8'h35. Then layer_enable = 5'b01111 -> 8'h47.
- All sources with low nibble 0 -> 8'h00. pixel_valid = 0 with opaque inputs -> output_pixel = 8'h00, output_valid = 0.
- Opaque sprite p = 3 over opaque L3 at (x = 100, y = 20), then a second collision at (101, 20) -> flag = 1 and coordinates (100, 20) retained. collision_clear -> flag 0 in the next cycle.
- collision_clear in the same cycle as a stage-2 collision at (200, 50) -> flag stays 1, coordinates = (200, 50).
- Stream of 10 valid pixels with reset pulsed on pixel 5 -> all outputs 0 during reset, output_valid 0 for 2 cycles after release, then pixels resume in order.

Source files
------------

// File: rtl/vdp_layer_mixer_if.sv
// rtl/vdp_layer_mixer_if.sv - pixel/collision bundle between sprite core, mixer and palette stage
interface vdp_layer_mixer_if;
  logic       pixel_valid;
  logic       start_new_frame;
  logic [9:0] render_x;
  logic [8:0] render_y;
  logic [4:0] layer_enable;
  logic [7:0] sprite_pixel;
  logic [1:0] sprite_priority;
  logic [7:0] layer0_pixel;
  logic [7:0] layer1_pixel;
  logic [7:0] layer2_pixel;
  logic [7:0] layer3_pixel;
  logic       collision_clear;
  logic [7:0] output_pixel;
  logic       output_valid;
  logic       collision_flag;
  logic [9:0] collision_x;
  logic [8:0] collision_y;

  modport master (
    output pixel_valid, start_new_frame, render_x, render_y, layer_enable,
           sprite_pixel, sprite_priority, layer0_pixel, layer1_pixel,
           layer2_pixel, layer3_pixel, collision_clear,
    input  output_pixel, output_valid, collision_flag, collision_x, collision_y
  );

  modport slave (
    input  pixel_valid, start_new_frame, render_x, render_y, layer_enable,
           sprite_pixel, sprite_priority, layer0_pixel, layer1_pixel,
           layer2_pixel, layer3_pixel, collision_clear,
    output output_pixel, output_valid, collision_flag, collision_x, collision_y
  );
endinterface

// File: rtl/vdp_layer_mixer.sv
// rtl/vdp_layer_mixer.sv - two-stage sprite/tilemap compositor with first-collision latch
module vdp_layer_mixer #(
  parameter int COLLISION_ENABLE = 1
) (
  input logic              clk,
  input logic              reset,
  vdp_layer_mixer_if.slave bus
);

  typedef enum logic {ARMED, LATCHED} coll_state_t;

  logic       s1_valid;
  logic [9:0] s1_x;
  logic [8:0] s1_y;
  logic [7:0] s1_sprite;
  logic [1:0] s1_prio;
  logic [7:0] s1_layer [4];
  logic       s1_sprite_op;
  logic [3:0] s1_layer_op;

  logic [7:0] resolved;
  logic       found;
  logic [1:0] sprite_slot;

  logic [7:0] out_pixel;
  logic       out_valid;

  // Stage 1: register the pixel and decide opacity with the enables that came with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_x         <= '0;
      s1_y         <= '0;
      s1_sprite    <= '0;
      s1_prio      <= '0;
      s1_sprite_op <= 1'b0;
      s1_layer_op  <= '0;
      for (int i = 0; i < 4; i++) s1_layer[i] <= '0;
    end else begin
      s1_valid     <= bus.pixel_valid;
      s1_x         <= bus.render_x;
      s1_y         <= bus.render_y;
      s1_sprite    <= bus.sprite_pixel;
      s1_prio      <= bus.sprite_priority;
      s1_sprite_op <= bus.layer_enable[4] && (bus.sprite_pixel[3:0] != 4'h0);
      s1_layer_op  <= {bus.layer_enable[3] && (bus.layer3_pixel[3:0] != 4'h0),
                       bus.layer_enable[2] && (bus.layer2_pixel[3:0] != 4'h0),
                       bus.layer_enable[1] && (bus.layer1_pixel[3:0] != 4'h0),
                       bus.layer_enable[0] && (bus.layer0_pixel[3:0] != 4'h0)};
      s1_layer[0]  <= bus.layer0_pixel;
      s1_layer[1]  <= bus.layer1_pixel;
      s1_layer[2]  <= bus.layer2_pixel;
      s1_layer[3]  <= bus.layer3_pixel;
    end
  end

  // Priority walk: the sprite is tried just before layer (3 - priority), so p=3 beats everything
  always_comb begin
    resolved    = 8'h00;
    found       = 1'b0;
    sprite_slot = 2'd3 - s1_prio;
    for (int i = 0; i < 4; i++) begin
      if (!found && (2'(i) == sprite_slot) && s1_sprite_op) begin
        resolved = s1_sprite;
        found    = 1'b1;
      end
      if (!found && s1_layer_op[i]) begin
        resolved = s1_layer[i];
        found    = 1'b1;
      end
    end
  end

  // Stage 2: register the resolved index, blanked to backdrop outside active display
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_pixel <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_pixel <= s1_valid ? resolved : 8'h00;
      out_valid <= s1_valid;
    end
  end

  assign bus.output_pixel = out_pixel;
  assign bus.output_valid = out_valid;

  generate
    if (COLLISION_ENABLE != 0) begin : g_coll
      coll_state_t state, next_state;
      logic        hit;
      logic        clear;
      logic        capture;
      logic [9:0]  cx;
      logic [8:0]  cy;

      assign hit   = s1_valid && s1_sprite_op && (s1_layer_op != 4'h0);
      assign clear = bus.collision_clear || bus.start_new_frame;

      // Collision state and captured coordinates
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= ARMED;
          cx    <= '0;
          cy    <= '0;
        end else begin
          state <= next_state;
          if (capture) begin
            cx <= s1_x;
            cy <= s1_y;
          end
        end
      end

      // A clear coinciding with a fresh hit re-captures rather than disarming
      always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
          ARMED: begin
            if (hit) begin
              next_state = LATCHED;
              capture    = 1'b1;
            end
          end
          LATCHED: begin
            if (clear) begin
              if (hit) capture = 1'b1;
              else next_state = ARMED;
            end
          end
          default: next_state = ARMED;
        endcase
      end

      assign bus.collision_flag = (state == LATCHED);
      assign bus.collision_x    = cx;
      assign bus.collision_y    = cy;
    end else begin : g_no_coll
      assign bus.collision_flag = 1'b0;
      assign bus.collision_x    = '0;
      assign bus.collision_y    = '0;
    end
  endgenerate

endmodule

// File: tb/tb_vdp_layer_mixer.sv
// tb/tb_vdp_layer_mixer.sv - directed self-checking bench for vdp_layer_mixer
module tb_vdp_layer_mixer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vdp_layer_mixer_if bus();

  vdp_layer_mixer #(.COLLISION_ENABLE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic px(input logic v, input logic [9:0] x, input logic [8:0] y,
                    input logic [4:0] en, input logic [7:0] spr, input logic [1:0] prio,
                    input logic [7:0] l0, input logic [7:0] l1,
                    input logic [7:0] l2, input logic [7:0] l3);
    bus.pixel_valid     = v;
    bus.render_x        = x;
    bus.render_y        = y;
    bus.layer_enable    = en;
    bus.sprite_pixel    = spr;
    bus.sprite_priority = prio;
    bus.layer0_pixel    = l0;
    bus.layer1_pixel    = l1;
    bus.layer2_pixel    = l2;
    bus.layer3_pixel    = l3;
  endtask

  // Present one pixel, then idle; outputs for it are visible after the second edge
  task automatic run_px(input logic v, input logic [9:0] x, input logic [8:0] y,
                        input logic [4:0] en, input logic [7:0] spr, input logic [1:0] prio,
                        input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] l2, input logic [7:0] l3);
    px(v, x, y, en, spr, prio, l0, l1, l2, l3);
    tick();
    bus.pixel_valid = 1'b0;
    tick();
  endtask

  logic       m1_v, m2_v;
  logic [7:0] m1_p, m2_p;
  logic [7:0] l0v;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.collision_clear = 1'b0;
    bus.start_new_frame = 1'b0;
    px(1'b0, 10'd0, 9'd0, 5'h1F, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    check("rst_pixel", 32'(bus.output_pixel), 32'h00);
    check("rst_valid", 32'(bus.output_valid), 32'h0);
    check("rst_flag", 32'(bus.collision_flag), 32'h0);
    check("rst_x", 32'(bus.collision_x), 32'h0);
    check("rst_y", 32'(bus.collision_y), 32'h0);
    reset = 1'b0;
    tick();

    run_px(1'b1, 10'd5, 9'd6, 5'h1F, 8'h35, 2'd1, 8'h00, 8'h12, 8'h47, 8'h00);
    check("t1_pixel", 32'(bus.output_pixel), 32'h12);
    check("t1_valid", 32'(bus.output_valid), 32'h1);
    check("t1_flag", 32'(bus.collision_flag), 32'h1);
    check("t1_x", 32'(bus.collision_x), 32'd5);
    check("t1_y", 32'(bus.collision_y), 32'd6);
    bus.start_new_frame = 1'b1;
    tick();
    bus.start_new_frame = 1'b0;
    check("sof_clear_flag", 32'(bus.collision_flag), 32'h0);

    run_px(1'b1, 10'd7, 9'd6, 5'h1F, 8'h35, 2'd1, 8'h00, 8'h10, 8'h47, 8'h00);
    check("l1_transp", 32'(bus.output_pixel), 32'h35);
    run_px(1'b1, 10'd8, 9'd6, 5'h0F, 8'h35, 2'd1, 8'h00, 8'h10, 8'h47, 8'h00);
    check("spr_disabled", 32'(bus.output_pixel), 32'h47);
    run_px(1'b1, 10'd9, 9'd6, 5'h1F, 8'h30, 2'd3, 8'h10, 8'h20, 8'h40, 8'h80);
    check("backdrop", 32'(bus.output_pixel), 32'h00);
    check("backdrop_valid", 32'(bus.output_valid), 32'h1);
    run_px(1'b0, 10'd9, 9'd6, 5'h1F, 8'h35, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44);
    check("invalid_pixel", 32'(bus.output_pixel), 32'h00);
    check("invalid_valid", 32'(bus.output_valid), 32'h0);
    run_px(1'b1, 10'd9, 9'd6, 5'h1F, 8'h2A, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44);
    check("p3_front", 32'(bus.output_pixel), 32'h2A);
    run_px(1'b1, 10'd9, 9'd6, 5'h1F, 8'h2A, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44);
    check("p2_behind_l0", 32'(bus.output_pixel), 32'h11);
    run_px(1'b1, 10'd9, 9'd6, 5'h1F, 8'h2A, 2'd2, 8'h00, 8'h22, 8'h33, 8'h44);
    check("p2_over_l1", 32'(bus.output_pixel), 32'h2A);
    run_px(1'b1, 10'd9, 9'd6, 5'h1F, 8'h2A, 2'd0, 8'h00, 8'h00, 8'h00, 8'h44);
    check("p0_over_l3", 32'(bus.output_pixel), 32'h2A);
    run_px(1'b1, 10'd9, 9'd6, 5'h1F, 8'h2A, 2'd0, 8'h00, 8'h00, 8'h33, 8'h44);
    check("p0_behind_l2", 32'(bus.output_pixel), 32'h33);

    bus.collision_clear = 1'b1;
    tick();
    bus.collision_clear = 1'b0;
    check("clr_flag", 32'(bus.collision_flag), 32'h0);

    run_px(1'b1, 10'd100, 9'd20, 5'h1F, 8'h3F, 2'd3, 8'h00, 8'h00, 8'h00, 8'h21);
    check("c1_pixel", 32'(bus.output_pixel), 32'h3F);
    check("c1_flag", 32'(bus.collision_flag), 32'h1);
    check("c1_x", 32'(bus.collision_x), 32'd100);
    check("c1_y", 32'(bus.collision_y), 32'd20);
    run_px(1'b1, 10'd101, 9'd20, 5'h1F, 8'h3F, 2'd3, 8'h00, 8'h00, 8'h00, 8'h21);
    check("c2_flag", 32'(bus.collision_flag), 32'h1);
    check("c2_x_kept", 32'(bus.collision_x), 32'd100);
    check("c2_y_kept", 32'(bus.collision_y), 32'd20);
    bus.collision_clear = 1'b1;
    tick();
    bus.collision_clear = 1'b0;
    check("c_clr_flag", 32'(bus.collision_flag), 32'h0);
    check("c_clr_x_hold", 32'(bus.collision_x), 32'd100);

    run_px(1'b1, 10'd10, 9'd10, 5'h1F, 8'h3F, 2'd3, 8'h00, 8'h00, 8'h00, 8'h21);
    check("pre_sim_flag", 32'(bus.collision_flag), 32'h1);
    px(1'b1, 10'd200, 9'd50, 5'h1F, 8'h3F, 2'd3, 8'h00, 8'h00, 8'h00, 8'h21);
    tick();
    bus.pixel_valid     = 1'b0;
    bus.collision_clear = 1'b1;
    tick();
    bus.collision_clear = 1'b0;
    check("sim_flag", 32'(bus.collision_flag), 32'h1);
    check("sim_x", 32'(bus.collision_x), 32'd200);
    check("sim_y", 32'(bus.collision_y), 32'd50);
    bus.collision_clear = 1'b1;
    bus.start_new_frame = 1'b1;
    tick();
    bus.collision_clear = 1'b0;
    bus.start_new_frame = 1'b0;
    check("dual_clr_flag", 32'(bus.collision_flag), 32'h0);
    tick();
    check("dual_clr_flag2", 32'(bus.collision_flag), 32'h0);

    m1_v = 1'b0; m2_v = 1'b0; m1_p = 8'h00; m2_p = 8'h00;
    for (int k = 0; k < 12; k++) begin
      l0v = 8'(k * 16 + 1);
      if (k < 10) px(1'b1, 10'(k), 9'd7, 5'h1F, 8'h00, 2'd0, l0v, 8'h00, 8'h00, 8'h00);
      else bus.pixel_valid = 1'b0;
      if (k == 5) begin
        reset = 1'b1;
        #1;
        check("mid_rst_pixel", 32'(bus.output_pixel), 32'h00);
        check("mid_rst_valid", 32'(bus.output_valid), 32'h0);
        check("mid_rst_flag", 32'(bus.collision_flag), 32'h0);
        check("mid_rst_x", 32'(bus.collision_x), 32'h0);
      end
      tick();
      if (k == 5) begin
        reset = 1'b0;
        m1_v = 1'b0; m2_v = 1'b0;
      end else begin
        m2_v = m1_v; m2_p = m1_p;
        m1_v = bus.pixel_valid; m1_p = l0v;
      end
      check("stream_valid", 32'(bus.output_valid), 32'(m2_v));
      check("stream_pixel", 32'(bus.output_pixel), m2_v ? 32'(m2_p) : 32'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
